if_fetch_unit: RTL and testbench

- Instruction-fetch stage. Owns the program counter and issues requests to instruction memory.
- Drives the pc/instruction pair that the IF/ID pipeline register captures, i.e. it is the producer side of that interface.
- Accepts stall back-pressure from the hazard unit and PC redirects (branch/jump/flush) from later stages.
- At most one memory request outstanding. A one-entry skid buffer absorbs a response that arrives while the output is blocked.

---
 rtl/if_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem request at a time, feeds IF/ID.
// Latency: output valid the edge after imem_rvalid_i; 2 cycles/insn with 1-cycle memory.
// Backpressure: stall_i holds the output; a late response parks in a one-entry skid.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_insn_q, out_insn_d;
  logic        out_vld_q, out_vld_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_insn_q, skid_insn_d;

  logic can_load;
  logic xfer;
  logic req;
  logic load_rsp;
  logic load_skid;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    out_pc_d    = out_pc_q;
    out_insn_d  = out_insn_q;
    out_vld_d   = out_vld_q;
    skid_pc_d   = skid_pc_q;
    skid_insn_d = skid_insn_q;
    load_rsp    = 1'b0;
    load_skid   = 1'b0;

    can_load = ~out_vld_q | ~stall_i;
    xfer     = out_vld_q & ~stall_i;
    req      = (state_q == ST_REQ) & ~redirect_i & can_load;

    case (state_q)
      ST_REQ: begin
        if (redirect_i) begin
          pc_d = redirect_pc_i;
        end else if (req && imem_ready_i) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + 32'(PC_STEP);
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          // A response still in flight must be swallowed before the next request.
          state_d = imem_rvalid_i ? ST_REQ : ST_DROP;
        end else if (imem_rvalid_i) begin
          if (can_load) begin
            load_rsp = 1'b1;
            state_d  = ST_REQ;
          end else begin
            skid_pc_d   = fetch_pc_q;
            skid_insn_d = imem_rdata_i;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = ST_REQ;
        end else if (!stall_i) begin
          load_skid = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect_i) begin
          pc_d = redirect_pc_i;
        end
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    // Flush beats any load; a load beats the consume-clear.
    if (redirect_i) begin
      out_vld_d  = 1'b0;
      out_insn_d = NOP_INSN;
    end else if (load_rsp) begin
      out_pc_d   = fetch_pc_q;
      out_insn_d = imem_rdata_i;
      out_vld_d  = 1'b1;
    end else if (load_skid) begin
      out_pc_d   = skid_pc_q;
      out_insn_d = skid_insn_q;
      out_vld_d  = 1'b1;
    end else if (xfer) begin
      out_vld_d  = 1'b0;
      out_insn_d = NOP_INSN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= 32'h0;
      out_pc_q    <= 32'h0;
      out_insn_q  <= NOP_INSN;
      out_vld_q   <= 1'b0;
      skid_pc_q   <= 32'h0;
      skid_insn_q <= NOP_INSN;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      out_pc_q    <= out_pc_d;
      out_insn_q  <= out_insn_d;
      out_vld_q   <= out_vld_d;
      skid_pc_q   <= skid_pc_d;
      skid_insn_q <= skid_insn_d;
    end
  end

  assign imem_req_o    = req & rst_n;
  assign imem_addr_o   = pc_q;
  assign pc_o          = out_pc_q;
  assign instruction_o = out_insn_q;
  assign valid_o       = out_vld_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: random stall/redirect/memory timing against a stream model
// (each redirect restarts an arithmetic PC stream; delivered words must follow it in order).
module tb_if_fetch_unit;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_ready_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] instruction_o;
  logic        valid_o;

  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = 32'h0;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_pc;
  logic [31:0] w_insn;
  logic        w_vld;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .instruction_o(instruction_o), .valid_o(valid_o)
  );

  if_fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall_i(1'b0), .redirect_i(1'b0),
    .redirect_pc_i(32'h0), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ready_i(1'b1), .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
    .pc_o(w_pc), .instruction_o(w_insn), .valid_o(w_vld)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_req;
  int          delivered = 0;

  int unsigned p_stall = 0;
  int unsigned p_redir = 0;
  int unsigned lat_max = 0;
  bit          ready_rand = 1'b0;
  bit          pend = 1'b0;
  logic [31:0] paddr = 32'h0;
  int unsigned lat = 0;
  bit          acc_prev = 1'b0;
  logic [31:0] acc_addr = 32'h0;

  bit          pv = 1'b0;
  logic [31:0] ppc = 32'h0;
  logic [31:0] pin = 32'h0;
  logic [31:0] e;

  bit          w_acc = 1'b0;
  logic [31:0] w_acc_addr = 32'h0;
  int          w_nreq = 0;
  int          w_ndel = 0;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic restart(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 1024; k++) exp_q.push_back(start + 32'(k) * 32'd4);
    next_req = start;
  endtask

  // One cycle of stimulus plus the single-outstanding memory model.
  task automatic step();
    @(negedge clk);
    if (acc_prev) begin
      pend  = 1'b1;
      paddr = acc_addr;
      lat   = $urandom_range(0, lat_max);
    end
    if (pend && lat == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = insn_of(paddr);
      pend          = 1'b0;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
      if (pend) lat--;
    end
    stall_i    = ($urandom_range(0, 99) < p_stall);
    redirect_i = ($urandom_range(0, 99) < p_redir);
    if (redirect_i) begin
      redirect_pc_i = $urandom & 32'h0000_0FFC;
      restart(redirect_pc_i);
    end
    imem_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    acc_prev = imem_req_o & imem_ready_i;
    acc_addr = imem_addr_o;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_mid_wait();
    int n;
    n = 0;
    p_stall = 0;
    p_redir = 0;
    do begin
      step();
      n++;
    end while (!acc_prev && n < 100);
    total++;
    if (!acc_prev) begin
      bad++;
      $display("FAIL rst_wait_timeout: got no request in %0d cycles, want one", n);
    end
    @(negedge clk);
    rst_n         = 1'b0;
    imem_rvalid_i = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    pend          = 1'b0;
    acc_prev      = 1'b0;
    restart(RST_PC);
    #1;
    check("midrst_valid", 32'(valid_o), 32'h0);
    check("midrst_req", 32'(imem_req_o), 32'h0);
    check("midrst_insn", instruction_o, NOP);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    restart(RST_PC);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_insn", instruction_o, NOP);
    check("rst_req", 32'(imem_req_o), 32'h0);
    check("rst_addr", imem_addr_o, RST_PC);
    rst_n = 1'b1;

    run_cycles(40);

    p_stall = 30; p_redir = 5; lat_max = 3; ready_rand = 1'b1;
    run_cycles(3000);

    reset_mid_wait();

    p_stall = 50; p_redir = 3; lat_max = 2; ready_rand = 1'b1;
    run_cycles(800);

    total++;
    if (delivered < 300) begin
      bad++;
      $display("FAIL progress: got %0d deliveries want >= 300", delivered);
    end
    total++;
    if (w_nreq < 3 || w_ndel < 2) begin
      bad++;
      $display("FAIL wrap_progress: got req=%0d del=%0d want >=3 and >=2", w_nreq, w_ndel);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: looks at what the next edge will do with the settled inputs.
  initial begin : mon
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (!valid_o) check("nop_idle", instruction_o, NOP);
        if (pv) begin
          check("stall_pc", pc_o, ppc);
          check("stall_insn", instruction_o, pin);
          check("stall_vld", 32'(valid_o), 32'h1);
        end
        pv  = valid_o & stall_i & ~redirect_i;
        ppc = pc_o;
        pin = instruction_o;
        if (imem_req_o && imem_ready_i) begin
          check("req_addr", imem_addr_o, next_req);
          next_req = next_req + 32'd4;
        end
        if (valid_o && !stall_i && !redirect_i) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out_extra: got pc %h want nothing", pc_o);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", pc_o, e);
            check("out_insn", instruction_o, insn_of(e));
            delivered++;
          end
        end
      end
    end
  end

  // Second instance starts at the top of the address space to exercise PC wrap.
  initial begin : wrap_mon
    forever begin
      @(negedge clk);
      w_rvalid = w_acc;
      w_rdata  = insn_of(w_acc_addr);
      #1;
      if (rst_n && w_req) begin
        if (w_nreq < 3) check("wrap_req", w_addr, WRAP_PC + 32'(w_nreq) * 32'd4);
        w_nreq++;
      end
      if (rst_n && w_vld) begin
        if (w_ndel < 2) begin
          check("wrap_pc", w_pc, WRAP_PC + 32'(w_ndel) * 32'd4);
          check("wrap_insn", w_insn, insn_of(WRAP_PC + 32'(w_ndel) * 32'd4));
        end
        w_ndel++;
      end
      w_acc      = rst_n & w_req;
      w_acc_addr = w_addr;
    end
  end

endmodule
